// File: rtl/scratch_pkg.sv
// Shared constants and types for the scrypt scratchpad memory controller.
package scratch_pkg;

    localparam int unsigned LINE_W  = 1024;
    localparam int unsigned MEM_DW  = 32;
    localparam int unsigned LINE_AW = 17;
    localparam int unsigned BEATS   = LINE_W / MEM_DW;
    localparam int unsigned BW      = $clog2(BEATS);
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned OW      = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} scratch_state_t;

    typedef logic [LINE_W-1:0] scratch_line_t;
    typedef logic [BEATS-1:0][MEM_DW-1:0] scratch_beats_t;

endpackage

// File: rtl/scratch_beat_ctr.sv
// Beat counter with synchronous clear, enable and terminal-beat flag; wraps at BEATS.
module scratch_beat_ctr
    import scratch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [BW-1:0] beat,
    output logic          last
);

    assign last = (beat == BW'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (en) begin
            beat <= last ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: rtl/scratch_mem_ctrl.sv
// Serialises 1024-bit scratchpad line reads/writes into 32-bit SRAM beats.
// Define SCRATCH_PARITY_EN to add even-parity generation/checking on the SRAM bus.
module scratch_mem_ctrl
    import scratch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scratch_read,
    input  logic                  scratch_write,
    input  logic [LINE_AW-1:0]    scratch_addr,
    input  logic [LINE_W-1:0]     scratch_in,
    output logic [LINE_W-1:0]     scratch_out,
    output logic                  scratch_busy,
    output logic                  scratch_done,
    output logic [LINE_AW+BW-1:0] mem_addr,
    output logic [MEM_DW-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic                  mem_ready,
    input  logic [MEM_DW-1:0]     mem_rdata,
`ifdef SCRATCH_PARITY_EN
    output logic                  mem_wpar,
    input  logic                  mem_rpar,
    output logic                  parity_err,
`endif
    input  logic                  mem_rvalid
);

    scratch_state_t       state;
    logic [LINE_AW-1:0]   line_q;
    scratch_beats_t       wbuf;
    scratch_beats_t       rbuf;
    scratch_beats_t       rline;
    logic [OW-1:0]        outst;
    logic                 iss_done;
    logic [BW-1:0]        wbeat, ibeat, rbeat;
    logic                 wlast, ilast, rlast;
    logic                 rd_acc, rd_ret, idle;

    assign idle   = (state == IDLE);
    assign mem_we = (state == WR);
    assign mem_re = (state == RD) && !iss_done && (outst < OW'(MAX_OUT));
    assign rd_acc = mem_re && mem_ready;
    // Returns outside RD belong to an aborted or foreign transfer.
    assign rd_ret = (state == RD) && mem_rvalid;

    assign mem_wdata = mem_we ? wbuf[wbeat] : '0;

    always_comb begin
        mem_addr = '0;
        if (mem_we) begin
            mem_addr = {line_q, wbeat};
        end else if (mem_re) begin
            mem_addr = {line_q, ibeat};
        end
    end

    always_comb begin
        rline        = rbuf;
        rline[rbeat] = mem_rdata;
    end

    scratch_beat_ctr u_wr_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .en   (mem_we && mem_ready),
        .beat (wbeat),
        .last (wlast)
    );

    scratch_beat_ctr u_iss_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .en   (rd_acc),
        .beat (ibeat),
        .last (ilast)
    );

    scratch_beat_ctr u_col_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .en   (rd_ret),
        .beat (rbeat),
        .last (rlast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            line_q       <= '0;
            wbuf         <= '0;
            scratch_out  <= '0;
            scratch_busy <= 1'b0;
            scratch_done <= 1'b0;
        end else begin
            scratch_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (scratch_write) begin
                        line_q       <= scratch_addr;
                        wbuf         <= scratch_in;
                        scratch_busy <= 1'b1;
                        state        <= WR;
                    end else if (scratch_read) begin
                        line_q       <= scratch_addr;
                        scratch_busy <= 1'b1;
                        state        <= RD;
                    end
                end
                WR: begin
                    if (mem_ready && wlast) begin
                        scratch_busy <= 1'b0;
                        scratch_done <= 1'b1;
                        state        <= DONE;
                    end
                end
                RD: begin
                    if (rd_ret && rlast) begin
                        scratch_out  <= rline;
                        scratch_busy <= 1'b0;
                        scratch_done <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf     <= '0;
            outst    <= '0;
            iss_done <= 1'b0;
        end else if (idle) begin
            outst    <= '0;
            iss_done <= 1'b0;
        end else begin
            if (rd_ret) begin
                rbuf[rbeat] <= mem_rdata;
            end
            if (rd_acc && ilast) begin
                iss_done <= 1'b1;
            end
            if (rd_acc && !rd_ret) begin
                outst <= outst + 1'b1;
            end else if (!rd_acc && rd_ret && (outst != '0)) begin
                outst <= outst - 1'b1;
            end
        end
    end

`ifdef SCRATCH_PARITY_EN
    assign mem_wpar = ^mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if ((rd_ret && ((^mem_rdata) != mem_rpar)) ||
                     (idle && scratch_read && scratch_write)) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_scratch_mem_ctrl.sv
// Self-checking bench for scratch_mem_ctrl with a behavioural SRAM and line-level reference.
`timescale 1ns/1ps
module tb_scratch_mem_ctrl;
    import scratch_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  scratch_read, scratch_write;
    logic [LINE_AW-1:0]    scratch_addr;
    logic [LINE_W-1:0]     scratch_in, scratch_out;
    logic                  scratch_busy, scratch_done;
    logic [LINE_AW+BW-1:0] mem_addr;
    logic [MEM_DW-1:0]     mem_wdata, mem_rdata;
    logic                  mem_we, mem_re, mem_ready, mem_rvalid;
`ifdef SCRATCH_PARITY_EN
    logic                  mem_wpar, mem_rpar, parity_err;
`endif

    scratch_mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .scratch_read  (scratch_read),
        .scratch_write (scratch_write),
        .scratch_addr  (scratch_addr),
        .scratch_in    (scratch_in),
        .scratch_out   (scratch_out),
        .scratch_busy  (scratch_busy),
        .scratch_done  (scratch_done),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
`ifdef SCRATCH_PARITY_EN
        .mem_wpar      (mem_wpar),
        .mem_rpar      (mem_rpar),
        .parity_err    (parity_err),
`endif
        .mem_rvalid    (mem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Behavioural SRAM: word store plus an in-order return pipeline of fixed latency.
    typedef struct { int due; logic [31:0] data; } rsp_t;
    logic [31:0]   sram [int];
    rsp_t          rq [$];
    logic [1023:0] ref_mem [int];
    int            rd_lat = 2;
    bit            rand_ready = 1'b0;
    int            corrupt_beat = -1;
    int            ret_idx, acc_cnt, max_out;
    bit            both_hi, re_seen, order_bad, wpar_bad;
    logic [21:0]   exp_addr;

    initial begin
        rsp_t r;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef SCRATCH_PARITY_EN
        mem_rpar = 1'b0;
`endif
        forever begin
            @(negedge clk);
            if (mem_we && mem_re) both_hi = 1'b1;
            if (mem_re) re_seen = 1'b1;
            if (rq.size() > max_out) max_out = rq.size();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = r.data;
`ifdef SCRATCH_PARITY_EN
                mem_rpar = (^r.data) ^ (ret_idx == corrupt_beat);
`endif
                ret_idx++;
            end
            mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rst && mem_we && mem_ready) begin
                if (mem_addr !== exp_addr) order_bad = 1'b1;
                exp_addr++;
                sram[int'(mem_addr)] = mem_wdata;
`ifdef SCRATCH_PARITY_EN
                if (mem_wpar !== ^mem_wdata) wpar_bad = 1'b1;
`endif
            end
            if (!rst && mem_re && mem_ready) begin
                if (mem_addr !== exp_addr) order_bad = 1'b1;
                exp_addr++;
                r.due  = cyc + rd_lat;
                r.data = sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 32'(mem_addr);
                rq.push_back(r);
                acc_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [1023:0] got,
                              input logic [1023:0] exp);
        int  k = 0;
        bit  found = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (!found && got[j*32 +: 32] !== exp[j*32 +: 32]) begin
                k = j;
                found = 1'b1;
            end
        end
        check($sformatf("%s[beat %0d]", tag, k), 64'(got[k*32 +: 32]), 64'(exp[k*32 +: 32]));
    endtask

    function automatic logic [1023:0] exp_line(input logic [16:0] a);
        logic [1023:0] l;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        for (int j = 0; j < 32; j++) l[j*32 +: 32] = 32'({a, 5'(j)});
        return l;
    endfunction

    function automatic logic [1023:0] sram_line(input logic [16:0] a);
        logic [1023:0] l;
        for (int j = 0; j < 32; j++) begin
            int idx = int'({a, 5'(j)});
            l[j*32 +: 32] = sram.exists(idx) ? sram[idx] : 32'hxxxxxxxx;
        end
        return l;
    endfunction

    function automatic logic [1023:0] rand_line();
        logic [1023:0] l;
        for (int j = 0; j < 32; j++) l[j*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic run_req(input string tag, input bit wr, input bit rd, input logic [16:0] addr,
                           input logic [1023:0] data, output int lat);
        @(negedge clk);
        both_hi = 1'b0; re_seen = 1'b0; order_bad = 1'b0; wpar_bad = 1'b0;
        max_out = 0; ret_idx = 0; exp_addr = {addr, 5'd0};
        scratch_write = wr; scratch_read = rd; scratch_addr = addr; scratch_in = data;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        scratch_write = 1'b0; scratch_read = 1'b0;
        while (!scratch_done && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " done_seen"}, 64'(scratch_done), 64'd1);
        check({tag, " busy_at_done"}, 64'(scratch_busy), 64'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(scratch_done), 64'd0);
        if (wr) ref_mem[int'(addr)] = data;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " ctl"}, 64'({scratch_busy, scratch_done, mem_we, mem_re}), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check_line({tag, " scratch_out"}, scratch_out, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat, n;
        logic [1023:0] d, last_rd;
        logic [16:0]   ra;

        rst = 1'b1; scratch_read = 1'b0; scratch_write = 1'b0;
        scratch_addr = '0; scratch_in = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Directed write: beat i carries A5000000+i.
        for (int j = 0; j < 32; j++) d[j*32 +: 32] = 32'hA500_0000 + 32'(j);
        run_req("wr0", 1'b1, 1'b0, 17'h1ABCD, d, lat);
        check("wr0 latency", 64'(lat), 64'd33);
        check("wr0 order", 64'(order_bad), 64'd0);
        check("wr0 no_re", 64'(re_seen), 64'd0);
        check_line("wr0 sram", sram_line(17'h1ABCD), d);
        check("wr0 busy_after", 64'(scratch_busy), 64'd0);

        // Unwritten line: SRAM returns the word address.
        rd_lat = 2;
        run_req("rd5", 1'b0, 1'b1, 17'h00005, '0, lat);
        check("rd5 latency", 64'(lat), 64'd35);
        check_line("rd5 data", scratch_out, exp_line(17'h00005));
        check("rd5 max_out", 64'(max_out <= 4), 64'd1);
        check("rd5 order", 64'(order_bad), 64'd0);

        run_req("rdw", 1'b0, 1'b1, 17'h1ABCD, '0, lat);
        check("rdw latency", 64'(lat), 64'd35);
        check_line("rdw data", scratch_out, exp_line(17'h1ABCD));

        // Long latency saturates the outstanding limit.
        rd_lat = 5;
        run_req("rdL5", 1'b0, 1'b1, 17'h00005, '0, lat);
        check("rdL5 max_out", 64'(max_out), 64'd4);
        check_line("rdL5 data", scratch_out, exp_line(17'h00005));
        last_rd = exp_line(17'h00005);

        // Random stalls on both directions.
        rand_ready = 1'b1;
        rd_lat = 3;
        for (int t = 0; t < 3; t++) begin
            ra = 17'($urandom);
            d  = rand_line();
            run_req("swr", 1'b1, 1'b0, ra, d, lat);
            check("swr order", 64'(order_bad), 64'd0);
            check("swr both_hi", 64'(both_hi), 64'd0);
            check_line("swr sram", sram_line(ra), d);
            check_line("swr out_held", scratch_out, last_rd);
`ifdef SCRATCH_PARITY_EN
            check("swr wpar", 64'(wpar_bad), 64'd0);
`endif
            run_req("srd", 1'b0, 1'b1, ra, '0, lat);
            check("srd order", 64'(order_bad), 64'd0);
            check("srd both_hi", 64'(both_hi), 64'd0);
            check("srd max_out", 64'(max_out <= 4), 64'd1);
            check_line("srd data", scratch_out, exp_line(ra));
            last_rd = exp_line(ra);
        end
        run_req("srd5", 1'b0, 1'b1, 17'h00005, '0, lat);
        check_line("srd5 data", scratch_out, exp_line(17'h00005));
        rand_ready = 1'b0;
        rd_lat = 2;

`ifdef SCRATCH_PARITY_EN
        check("par clean", 64'(parity_err), 64'd0);
        corrupt_beat = 7;
        run_req("par", 1'b0, 1'b1, 17'h1ABCD, '0, lat);
        check_line("par data", scratch_out, exp_line(17'h1ABCD));
        check("par err", 64'(parity_err), 64'd1);
        corrupt_beat = -1;
        repeat (3) @(negedge clk);
        check("par sticky", 64'(parity_err), 64'd1);
`endif

        // Reset in the middle of a read, after 10 beats issued.
        @(negedge clk);
        acc_cnt = 0;
        scratch_read = 1'b1; scratch_addr = 17'h1ABCD;
        @(negedge clk);
        scratch_read = 1'b0;
        n = 0;
        while (acc_cnt < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstmid reached_beat10", 64'(acc_cnt >= 10), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_zero_outputs("rstmid");
`ifdef SCRATCH_PARITY_EN
        check("rstmid parity_err", 64'(parity_err), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (rq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("rstmid drained", 64'(rq.size()), 64'd0);
        check("rstmid idle_busy", 64'(scratch_busy), 64'd0);
        check_line("rstmid out_kept_zero", scratch_out, '0);
        run_req("rdafter", 1'b0, 1'b1, 17'h00005, '0, lat);
        check("rdafter latency", 64'(lat), 64'd35);
        check_line("rdafter data", scratch_out, exp_line(17'h00005));

        // Simultaneous read and write: write wins.
        d = rand_line();
        run_req("both", 1'b1, 1'b1, 17'h00777, d, lat);
        check("both latency", 64'(lat), 64'd33);
        check("both no_re", 64'(re_seen), 64'd0);
        check_line("both sram", sram_line(17'h00777), d);
`ifdef SCRATCH_PARITY_EN
        check("both parity_err", 64'(parity_err), 64'd1);
`endif
        run_req("bothrd", 1'b0, 1'b1, 17'h00777, '0, lat);
        check_line("bothrd data", scratch_out, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scratch_mem_ctrl.md
Name: scratch_mem_ctrl

Overview:
- Sits directly downstream of the scrypt hasher's scratchpad port.
- Accepts one 1024-bit line read or write per request and serialises it into 32-bit beats on an external single-port SRAM.
- On a read, reassembles the returned beats into a 1024-bit line on scratch_out.
- Gives the hasher a busy/done handshake so it can sequence its V-array accesses.

Parameters:
- LINE_W, 1024, scratchpad line width in bits.
- MEM_DW, 32, external SRAM data width; LINE_W must be a multiple of MEM_DW.
- LINE_AW, 17, line address width (scratch_addr).
- BEATS, LINE_W/MEM_DW (32), derived; beat index width BW = clog2(BEATS) = 5.
- MAX_OUT, 4, maximum read beats outstanding at the SRAM.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- scratch_read  in  1  read request strobe from hasher.
- scratch_write  in  1  write request strobe from hasher.
- scratch_addr  in  LINE_AW  line address.
- scratch_in  in  LINE_W  write line data.
- scratch_out  out  LINE_W  last completed read line.
- scratch_busy  out  1  high while a request is in progress.
- scratch_done  out  1  one-cycle completion pulse.
- mem_addr  out  LINE_AW+BW  SRAM word address, equal to {line, beat}.
- mem_wdata  out  MEM_DW  SRAM write data.
- mem_we  out  1  write command valid.
- mem_re  out  1  read command valid.
- mem_ready  in  1  SRAM accepts the command this cycle.
- mem_rdata  in  MEM_DW  read data.
- mem_rvalid  in  1  read data valid; returned in issue order.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset state: all outputs 0 (scratch_out, mem_addr and mem_wdata included), FSM IDLE, all counters 0.
- Reset mid-operation aborts the transfer immediately.
  - Any later mem_rvalid is ignored until a new read is issued.
- FSM states: IDLE, WR, RD, DONE.
- IDLE:
  - On scratch_write, latch scratch_addr and scratch_in, assert busy, go to WR.
  - On scratch_read, latch the address, go to RD.
  - If both are high, write wins and the read is dropped (see optional feature).
  - Requests arriving while busy are ignored.
  - The hasher must wait for scratch_done before issuing another request.
- WR:
  - Hold mem_we=1, mem_addr={line, wbeat}, mem_wdata = line bits [wbeat*32 +: 32].
  - wbeat advances only on mem_ready.
  - Beat 0 is bits [31:0].
  - When the last beat is accepted, go to DONE.
  - Minimum duration is 32 cycles.
- RD:
  - Issue and collect concurrently.
  - mem_re=1 while issued<BEATS and outstanding<MAX_OUT.
  - issue beat advances on mem_ready.
  - Each mem_rvalid writes mem_rdata into collect-buffer slot rbeat, then rbeat increments.
  - outstanding += accept − rvalid; a simultaneous accept and rvalid leaves it unchanged.
  - When beat 31 is received, copy the buffer to scratch_out (visible the next cycle) and go to DONE.
- scratch_out:
  - Changes only at read completion.
  - Holds its value through writes and idle periods.
- DONE: scratch_done=1 and busy=0 for exactly one cycle, then IDLE.
  - A request arriving in the DONE cycle is ignored.
- mem_we and mem_re are never high together.
  - mem_rvalid outside RD is ignored.
- Latency with mem_ready always high and read latency L:
  - write: request at cycle 0, done at cycle 33;
  - read: done at cycle 33+L when MAX_OUT ≥ L+1; otherwise throughput is limited to MAX_OUT beats per L+1 cycles.
- Counters wrap at BEATS; terminal detection uses beat == BEATS−1, never overflow.

Optional Feature:
- Macro SCRATCH_PARITY_EN.
- Defined:
  - Adds ports mem_wpar (out, 1), mem_rpar (in, 1) and parity_err (out, 1).
  - mem_wpar is the even parity of mem_wdata.
  - Each received beat is checked against mem_rpar.
  - Any mismatch sets sticky parity_err, cleared only by rst.
  - A simultaneous read+write request also sets parity_err.
- Undefined: ports absent, no check logic.
- All other behaviour is identical either way.

Decomposition:
- Package scratch_pkg holds:
  - LINE_W, MEM_DW, LINE_AW, BEATS and BW constants;
  - typedef enum logic [1:0] {IDLE, WR, RD, DONE} scratch_state_t;
  - typedef logic [LINE_W-1:0] scratch_line_t.
- One natural sub-module, scratch_beat_ctr: a BW-bit counter with clear, enable and terminal flag.
  - Instantiated three times: write beat, read issue beat, read collect beat.

Test Plan:
- Write addr 0x1ABCD, data = beat i carries 32'hA5000000+i, mem_ready=1 → 32 mem_we beats at mem_addr 0x3579A0..0x3579BF with matching data; done pulse at cycle 33; busy low afterwards.
- Read addr 0x00005 with a model returning data = word address, latency 2 → scratch_out[j*32+:32] = 0xA0+j for j in 0..31; done at cycle 35; outstanding never exceeds 4.
- Random mem_ready stalls (50%) on read and write → beat order preserved; data identical to the no-stall case; mem_we and mem_re never both high.
- rst asserted at beat 10 of a read → all outputs 0 asynchronously; after release, late mem_rvalid pulses are ignored; next read returns a correct line.
- scratch_read and scratch_write both high in IDLE → write performed, no mem_re; with SCRATCH_PARITY_EN, parity_err=1.
- SCRATCH_PARITY_EN with a corrupted mem_rpar on beat 7 → parity_err set and held; line still delivered with scratch_done.
